// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and receiver state encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        idle   = 3'd0,
        start  = 3'd1,
        data   = 3'd2,
        parity = 3'd3,
        stop   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input with a selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampled UART receiver: start, DBIT data bits LSB first, stop bit.
// Optional even-parity check is built when UART_RX_PARITY_EN is defined.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]    S_MID  = 5'(MID_SAMPLE);
    localparam logic [4:0]    S_BIT  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic rx_sync;

    rx_state_t       state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [DBIT-1:0] dout_reg, dout_next;
    logic            done_reg, done_next;
    logic            ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic            pbad_reg, pbad_next;
    logic            perr_reg, perr_next;
`endif

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= idle;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_reg  <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            pbad_reg  <= pbad_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    // Idle exit is clk-driven so the start-bit timing begins on the falling edge itself.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
`ifdef UART_RX_PARITY_EN
        pbad_next  = pbad_reg;
`endif
        case (state_reg)
            idle: begin
                if (!rx_sync) begin
                    state_next = start;
                    s_next     = '0;
                end
            end
            start: begin
                if (s_tick) begin
                    if (s_reg == S_MID) begin
                        if (!rx_sync) begin
                            state_next = data;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = idle;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            data: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        s_next = '0;
                        b_next = {rx_sync, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = parity;
`else
                            state_next = stop;
`endif
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            parity: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        s_next     = '0;
                        pbad_next  = (^b_reg) ^ rx_sync;
                        state_next = stop;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
`endif
            stop: begin
                if (s_tick) begin
                    if (s_reg == S_STOP) begin
                        state_next = idle;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = idle;
        endcase
    end

    // Outputs are registered so rx_dout is already valid in the strobe cycle.
    always_comb begin
        done_next = 1'b0;
        ferr_next = 1'b0;
        dout_next = dout_reg;
`ifdef UART_RX_PARITY_EN
        perr_next = 1'b0;
`endif
        if (state_reg == stop && s_tick && s_reg == S_STOP) begin
            done_next = 1'b1;
            ferr_next = ~rx_sync;
            dout_next = b_reg;
`ifdef UART_RX_PARITY_EN
            perr_next = pbad_reg;
`endif
        end
    end

    assign rx_dout      = dout_reg;
    assign rx_done_tick = done_reg;
    assign frame_err    = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_reg;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver; define UART_RX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_receiver;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    int   vectors = 0;
    int   miscompares = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];

    uart_receiver #(.DBIT(8), .SB_TICK(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .rx          (rx),
        .rx_dout     (rx_dout),
        .rx_done_tick(rx_done_tick),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // s_tick: one clk-wide pulse every 4 clk
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            s_tick = (cnt % 4 == 0);
        end
    end

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1)
            obs_q.push_back('{rx_dout, frame_err, parity_err});
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send_bit(input logic b, input int clks);
        rx = b;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_low, input logic par);
        rec_t e;
        e.d  = d;
        e.fe = stop_low;
`ifdef UART_RX_PARITY_EN
        e.pe = (^d) ^ par;
`else
        e.pe = 1'b0;
`endif
        exp_q.push_back(e);
        send_bit(1'b0, 64);
        for (int i = 0; i < 8; i++) send_bit(d[i], 64);
`ifdef UART_RX_PARITY_EN
        send_bit(par, 64);
`endif
        if (stop_low) begin
            send_bit(1'b0, 48);
            send_bit(1'b1, 16);
        end else begin
            send_bit(1'b1, 64);
        end
        send_bit(1'b1, 64);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (rx_dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", rx_dout); end
        vectors++;
        if (rx_done_tick !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", rx_done_tick); end
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        vectors++;
        if (parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        vectors++;
        if (dut.state_reg !== idle) begin miscompares++; $display("FAIL reset_state: got %0d want idle", dut.state_reg); end
        $display("test_reset: outputs and state checked");
    endtask

    task automatic test_idle_line();
        rx = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        vectors++;
        if (obs_q.size() !== 0) begin miscompares++; $display("FAIL idle_strobe: got %0d strobes want 0", obs_q.size()); end
        vectors++;
        if (rx_dout !== 8'h00) begin miscompares++; $display("FAIL idle_dout: got %h want 00", rx_dout); end
        $display("test_idle_line: 1000 idle cycles, %0d strobes", obs_q.size());
        obs_q.delete();
    endtask

    // Pops one expected/observed pair and compares; name identifies the scenario.
    task automatic test_frame(input string name, input logic [7:0] d, input logic stop_low, input logic par);
        rec_t e, o;
        int   k;
        send_frame(d, stop_low, par);
        k = 0;
        while (obs_q.size() == 0 && k < 200) begin @(posedge clk); k++; end
        #1;
        vectors++;
        if (obs_q.size() !== 1) begin
            miscompares++;
            $display("FAIL %s_count: got %0d strobes want 1", name, obs_q.size());
        end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.d !== e.d) begin miscompares++; $display("FAIL %s_data: got %h want %h", name, o.d, e.d); end
            vectors++;
            if (o.fe !== e.fe) begin miscompares++; $display("FAIL %s_ferr: got %b want %b", name, o.fe, e.fe); end
            vectors++;
            if (o.pe !== e.pe) begin miscompares++; $display("FAIL %s_perr: got %b want %b", name, o.pe, e.pe); end
            $display("%s: data=%h ferr=%b perr=%b", name, o.d, o.fe, o.pe);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_glitch();
        send_bit(1'b0, 8);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (dut.state_reg !== start) begin miscompares++; $display("FAIL glitch_detect: got %0d want start", dut.state_reg); end
        repeat (56) @(posedge clk);
        #1;
        vectors++;
        if (dut.state_reg !== idle) begin miscompares++; $display("FAIL glitch_return: got %0d want idle", dut.state_reg); end
        repeat (200) @(posedge clk);
        #1;
        vectors++;
        if (obs_q.size() !== 0) begin miscompares++; $display("FAIL glitch_strobe: got %0d want 0", obs_q.size()); end
        $display("test_glitch: state=%0d strobes=%0d", dut.state_reg, obs_q.size());
        obs_q.delete();
    endtask

    task automatic test_reset_midframe();
        send_bit(1'b0, 64);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 64);
        send_bit(1'b1, 32);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        vectors++;
        if (dut.state_reg !== idle) begin miscompares++; $display("FAIL midreset_state: got %0d want idle", dut.state_reg); end
        send_bit(1'b1, 400);
        vectors++;
        if (obs_q.size() !== 0) begin miscompares++; $display("FAIL midreset_strobe: got %0d want 0", obs_q.size()); end
        $display("test_reset_midframe: aborted 0xFF, strobes=%0d", obs_q.size());
        obs_q.delete();
        test_frame("after_reset_81", 8'h81, 1'b0, ^8'h81);
    endtask

    initial begin
        test_reset();
        test_idle_line();
        test_frame("frame_a5", 8'hA5, 1'b0, ^8'hA5);
        test_glitch();
        test_frame("frame_3c_stoplow", 8'h3C, 1'b1, ^8'h3C);
        test_reset_midframe();
        test_frame("frame_5a", 8'h5A, 1'b0, ^8'h5A);
`ifdef UART_RX_PARITY_EN
        test_frame("parity_07_p1", 8'h07, 1'b0, 1'b1);
        test_frame("parity_07_p0", 8'h07, 1'b0, 1'b0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
